oclib_csr_arbiter: RTL

OCLIB_CSR_ARBITER -- requirements
Module: oclib_csr_arbiter

---
 rtl/oclib_pkg.sv | 28 ++
 rtl/oclib_rr_arbiter.sv | 24 ++
 rtl/oclib_csr_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/oclib_pkg.sv
// Shared CSR bus payload types and the CSR arbiter state encoding.
package oclib_pkg;

  localparam int unsigned CsrSpaceW = 4;
  localparam int unsigned CsrAddrW  = 32;
  localparam int unsigned CsrDataW  = 32;

  typedef struct packed {
    logic                 read;
    logic                 write;
    logic [CsrSpaceW-1:0] space;
    logic [CsrAddrW-1:0]  address;
    logic [CsrDataW-1:0]  wdata;
  } csr_32_s;

  typedef struct packed {
    logic                ready;
    logic                error;
    logic [CsrDataW-1:0] rdata;
  } csr_32_fb_s;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY,
    ARB_DONE
  } csr_arb_state_e;

endpackage

// File: rtl/oclib_rr_arbiter.sv
// Combinational round-robin pick: lowest requester above the last grant, else lowest overall.
module oclib_rr_arbiter #(
  parameter int unsigned Width = 2
) (
  input  logic [Width-1:0] i_req,
  input  logic [Width-1:0] i_last,
  output logic [Width-1:0] o_gnt_c
);

  logic [Width-1:0] w_mask;
  logic [Width-1:0] w_req_hi;

  // Mask keeps only positions strictly above the one-hot last grant
  always_comb begin
    w_mask   = ~((i_last << 1) - Width'(1));
    w_req_hi = i_req & w_mask;
    if (|w_req_hi) begin
      o_gnt_c = w_req_hi & (~w_req_hi + Width'(1));
    end else begin
      o_gnt_c = i_req & (~i_req + Width'(1));
    end
  end

endmodule

// File: rtl/oclib_csr_arbiter.sv
// Merges several CSR initiators onto one target, one transaction at a time,
// with round-robin fairness and an optional downstream timeout.
module oclib_csr_arbiter
  import oclib_pkg::*;
#(
  parameter type         CsrType       = oclib_pkg::csr_32_s,
  parameter type         CsrFbType     = oclib_pkg::csr_32_fb_s,
  parameter int unsigned Inputs        = 2,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  CsrType            in    [0:Inputs-1],
  output CsrFbType          inFb  [0:Inputs-1],
  output CsrType            out,
  input  CsrFbType          outFb,
  output logic [Inputs-1:0] grant
);

  localparam int unsigned CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;

  csr_arb_state_e    r_state;
  csr_arb_state_e    w_state_next;
  CsrType            r_out;
  CsrFbType          r_infb [0:Inputs-1];
  logic [Inputs-1:0] r_grant;
  logic [Inputs-1:0] r_last;
  logic [CntW-1:0]   r_cnt;
  logic              r_armed;

  logic [Inputs-1:0] w_req;
  logic [Inputs-1:0] w_pick;
  CsrType            w_sel_req;
  logic              w_take;
  logic              w_resp;
  logic              w_tmo;
  logic              w_tmo_hit;

  always_comb begin
    w_req = '0;
    for (int i = 0; i < Inputs; i++) begin
      w_req[i] = in[i].read | in[i].write;
    end
  end

  oclib_rr_arbiter #(
    .Width (Inputs)
  ) u_rr (
    .i_req   (w_req),
    .i_last  (r_last),
    .o_gnt_c (w_pick)
  );

  always_comb begin
    w_sel_req = '0;
    for (int i = 0; i < Inputs; i++) begin
      if (w_pick[i]) w_sel_req = in[i];
    end
  end

  assign w_tmo_hit = (TimeoutCycles != 0) && (r_cnt == CntW'(TimeoutCycles));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ARB_IDLE;
    else       r_state <= w_state_next;
  end

  // A real response beats a timeout landing in the same cycle
  always_comb begin
    w_state_next = r_state;
    w_take       = 1'b0;
    w_resp       = 1'b0;
    w_tmo        = 1'b0;
    unique case (r_state)
      ARB_IDLE: begin
        if (r_armed && (|w_req)) begin
          w_take       = 1'b1;
          w_state_next = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (outFb.ready) begin
          w_resp       = 1'b1;
          w_state_next = ARB_DONE;
        end else if (w_tmo_hit) begin
          w_tmo        = 1'b1;
          w_state_next = ARB_DONE;
        end
      end
      ARB_DONE: w_state_next = ARB_IDLE;
      default:  w_state_next = ARB_IDLE;
    endcase
  end

  // r_armed blocks arbitration on the first edge after reset release
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_out   <= '0;
      r_grant <= '0;
      r_last  <= {1'b1, {(Inputs-1){1'b0}}};
      r_cnt   <= '0;
      r_armed <= 1'b0;
      for (int i = 0; i < Inputs; i++) r_infb[i] <= '0;
    end else begin
      r_armed <= 1'b1;
      if (w_take) begin
        r_out   <= w_sel_req;
        r_grant <= w_pick;
        r_cnt   <= '0;
      end
      if (r_state == ARB_BUSY) r_cnt <= r_cnt + CntW'(1);
      if (w_resp || w_tmo) begin
        r_out.read  <= 1'b0;
        r_out.write <= 1'b0;
      end
      for (int i = 0; i < Inputs; i++) begin
        if ((w_resp || w_tmo) && r_grant[i]) begin
          r_infb[i].ready <= 1'b1;
          r_infb[i].error <= w_resp ? outFb.error : 1'b1;
          r_infb[i].rdata <= w_resp ? outFb.rdata : '0;
        end else if (r_state == ARB_DONE) begin
          r_infb[i] <= '0;
        end
      end
      if (r_state == ARB_DONE) begin
        r_grant <= '0;
        r_last  <= r_grant;
      end
    end
  end

  assign out   = r_out;
  assign inFb  = r_infb;
  assign grant = r_grant;

endmodule
